// File: rtl/acc_cpu_pkg.sv
// Shared opcode/state encodings and instruction-field positions for the
// multi-cycle accumulator CPU.
package acc_cpu_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPD_W   = 12;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDR  = 4'h2,
        OP_STR  = 4'h3,
        OP_LDM  = 4'h4,
        OP_STM  = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_ADDI = 4'h8,
        OP_AND  = 4'h9,
        OP_OR   = 4'hA,
        OP_XOR  = 4'hB,
        OP_JMP  = 4'hC,
        OP_JC   = 4'hD,
        OP_JZ   = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HLT   = 2'd3
    } state_e;

endpackage

// File: rtl/acc_cpu_if.sv
// Instruction- and data-memory req/ack buses; the core is the master.
interface acc_cpu_if #(
    parameter int PC_WIDTH        = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int DMEM_ADDR_WIDTH = 10
);
    logic                       imem_req;
    logic [PC_WIDTH-1:0]        imem_addr;
    logic                       imem_ack;
    logic [15:0]                imem_rdata;

    logic                       dmem_req;
    logic                       dmem_we;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0]      dmem_wdata;
    logic                       dmem_ack;
    logic [DATA_WIDTH-1:0]      dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the new accumulator value and carry/borrow
// for register/immediate operations.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] operand,
    input  opcode_e               opcode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out,
    output logic                  wr_acc
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    // The extra MSB of diff is the borrow (a < operand).
    assign sum  = {1'b0, a} + {1'b0, operand};
    assign diff = {1'b0, a} - {1'b0, operand};

    always_comb begin
        result    = a;
        carry_out = 1'b0;
        wr_acc    = 1'b0;
        case (opcode)
            OP_LDI, OP_LDR: begin
                result = operand;
                wr_acc = 1'b1;
            end
            OP_ADD, OP_ADDI: begin
                result    = sum[DATA_WIDTH-1:0];
                carry_out = sum[DATA_WIDTH];
                wr_acc    = 1'b1;
            end
            OP_SUB: begin
                result    = diff[DATA_WIDTH-1:0];
                carry_out = diff[DATA_WIDTH];
                wr_acc    = 1'b1;
            end
            OP_AND: begin
                result = a & operand;
                wr_acc = 1'b1;
            end
            OP_OR: begin
                result = a | operand;
                wr_acc = 1'b1;
            end
            OP_XOR: begin
                result = a ^ operand;
                wr_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/MEM/HLT sequencing over req/ack
// instruction and data buses, with A, C, Z and a small register file.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int RF_DEPTH        = 4,
    parameter int PC_WIDTH        = 8,
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    acc_cpu_if.master             bus,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] acc_dbg
);

    localparam int RW = $clog2(RF_DEPTH);

    state_e                state, state_nx;
    logic                  started;
    logic [15:0]           ir;
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] acc;
    logic                  c_flag;
    logic                  z_flag;
    logic [DATA_WIDTH-1:0] rf [RF_DEPTH];

    opcode_e               opc;
    logic [OPD_W-1:0]      opd;
    logic [RW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] rf_val;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c;
    logic                  alu_wr;
    logic                  take_jmp;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic                  fetch_done;
    logic                  mem_done;
    logic                  unused_ir;

    assign opc      = opcode_e'(ir[OPC_MSB:OPC_LSB]);
    assign opd      = ir[OPD_W-1:0];
    assign r_idx    = opd[RW-1:0];
    assign imm      = DATA_WIDTH'(opd[7:0]);
    assign rf_val   = rf[r_idx];
    assign alu_b    = (opc == OP_LDI || opc == OP_ADDI) ? imm : rf_val;
    assign pc_inc   = pc + PC_WIDTH'(1);
    assign take_jmp = (opc == OP_JMP) || (opc == OP_JC && c_flag) || (opc == OP_JZ && z_flag);
    assign unused_ir = ^ir;

    assign fetch_done = bus.imem_req && bus.imem_ack;
    assign mem_done   = bus.dmem_req && bus.dmem_ack;

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = opd[DMEM_ADDR_WIDTH-1:0];
    assign bus.dmem_wdata = acc;
    assign acc_dbg        = acc;

    acc_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a         (acc),
        .operand   (alu_b),
        .opcode    (opc),
        .result    (alu_res),
        .carry_out (alu_c),
        .wr_acc    (alu_wr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    // started keeps imem_req low in the first cycle after reset so the
    // reset-state FETCH never requests while rst is still asserted.
    always_comb begin
        state_nx     = state;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        halted       = 1'b0;
        case (state)
            FETCH: begin
                bus.imem_req = started;
                if (fetch_done) state_nx = EXEC;
            end
            EXEC: begin
                case (opc)
                    OP_LDM, OP_STM: state_nx = MEM;
                    OP_HALT:        state_nx = HLT;
                    default:        state_nx = FETCH;
                endcase
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (opc == OP_STM);
                if (mem_done) state_nx = FETCH;
            end
            HLT: halted = 1'b1;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started <= 1'b0;
            ir      <= '0;
            pc      <= '0;
            acc     <= '0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                FETCH: if (fetch_done) ir <= bus.imem_rdata;
                EXEC: begin
                    if (alu_wr) begin
                        acc    <= alu_res;
                        z_flag <= (alu_res == '0);
                    end
                    if (opc == OP_ADD || opc == OP_ADDI || opc == OP_SUB) c_flag <= alu_c;
                    if (opc == OP_STR) rf[r_idx] <= acc;
                    if (!(opc == OP_LDM || opc == OP_STM || opc == OP_HALT)) begin
                        if (take_jmp) pc <= opd[PC_WIDTH-1:0];
                        else          pc <= pc_inc;
                    end
                end
                MEM: begin
                    if (mem_done) begin
                        if (opc == OP_LDM) begin
                            acc    <= bus.dmem_rdata;
                            z_flag <= (bus.dmem_rdata == '0);
                        end
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
